// File: rtl/mw_pkg.sv
// mw_pkg: shared definitions for the microwave countdown timer.
//   state_e           : timer FSM states (IDLE, SET, RUN)
//   BCD_W             : width of one BCD digit
//   BCD_MAX           : largest legal BCD digit value
//   DIGIT_INVALID_MIN : first keypad code that is not a BCD digit
package mw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int             BCD_W             = 4;
    localparam logic [BCD_W-1:0] BCD_MAX         = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_INVALID_MIN = 4'd10;

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit register of the countdown chain.
//   clk_i      : system clock, rising edge
//   rst_i      : synchronous active-high reset, clears the digit
//   clr_i      : synchronous clear (highest priority after reset)
//   ld_i       : load ld_val_i into the digit
//   ld_val_i   : value to load
//   dec_i      : decrement enable; at 0 the digit wraps to RELOAD
//   q_o        : current digit value
//   borrow_o   : high while the digit is 0 (a decrement here borrows)
module bcd_down_digit
    import mw_pkg::*;
#(
    parameter logic [BCD_W-1:0] RELOAD = BCD_MAX
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [BCD_W-1:0] ld_val_i,
    input  logic             dec_i,
    output logic [BCD_W-1:0] q_o,
    output logic             borrow_o
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = ld_val_i;
        end else if (dec_i) begin
            q_d = (q_q == '0) ? RELOAD : (q_q - 4'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign borrow_o = (q_q == '0);

endmodule

// File: rtl/mw_timer.sv
// mw_timer: microwave cook-time countdown (MM:SS, four BCD digits).
//   clk                : system clock, rising edge
//   rst                : synchronous active-high reset
//   tick_1hz           : one-cycle pulse per second
//   clearn             : keypad clear, active-low
//   load / digit       : keypad strobe and BCD digit (10-15 ignored)
//   mag_on             : magnetron running; entry locked out, counting enabled
//   min_tens..sec_ones : current time, BCD
//   timer_done         : high while the time is 00:00
//   done_pulse         : one-cycle pulse when a countdown reaches 00:00
module mw_timer
    import mw_pkg::*;
#(
    parameter logic [3:0] SEC_TENS_RELOAD = 4'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       clearn,
    input  logic       load,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse
);

    state_e state_q, state_d;
    logic   done_pulse_q, done_pulse_d;

    logic   clr;
    logic   key_ok;
    logic   tick_run;
    logic   so_bor, st_bor, mo_bor, mt_bor;
    logic   at_one;

    assign clr    = !clearn;
    // Entry is locked while the magnetron runs; clear outranks entry.
    assign key_ok = load && !mag_on && (digit < DIGIT_INVALID_MIN);
    // Pause wins over a tick arriving as mag_on drops.
    assign tick_run = tick_1hz && mag_on && (state_q == ST_RUN);

    // Borrow chain: a digit decrements only when every lower digit is 0.
    bcd_down_digit #(.RELOAD(BCD_MAX)) u_sec_ones (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(key_ok), .ld_val_i(digit),
        .dec_i(tick_run), .q_o(sec_ones), .borrow_o(so_bor)
    );

    bcd_down_digit #(.RELOAD(SEC_TENS_RELOAD)) u_sec_tens (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(key_ok), .ld_val_i(sec_ones),
        .dec_i(tick_run && so_bor), .q_o(sec_tens), .borrow_o(st_bor)
    );

    bcd_down_digit #(.RELOAD(BCD_MAX)) u_min_ones (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(key_ok), .ld_val_i(sec_tens),
        .dec_i(tick_run && so_bor && st_bor), .q_o(min_ones), .borrow_o(mo_bor)
    );

    bcd_down_digit #(.RELOAD(BCD_MAX)) u_min_tens (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .ld_i(key_ok), .ld_val_i(min_ones),
        .dec_i(tick_run && so_bor && st_bor && mo_bor), .q_o(min_tens), .borrow_o(mt_bor)
    );

    // The only decrement that lands on 00:00 is the one from 00:01.
    assign at_one = mt_bor && mo_bor && st_bor && (sec_ones == 4'd1);

    always_comb begin
        state_d      = state_q;
        done_pulse_d = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (key_ok) begin
            // Time after the shift; old min_tens drops off the top.
            state_d = ({min_ones, sec_tens, sec_ones, digit} != '0) ? ST_SET : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_SET: begin
                    if (mag_on) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!mag_on) begin
                        state_d = ST_SET;
                    end else if (tick_1hz && at_one) begin
                        state_d      = ST_IDLE;
                        done_pulse_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign timer_done = mt_bor && mo_bor && st_bor && so_bor;
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_mw_timer.sv
module tb_mw_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       clearn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       mag_on = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, done_pulse;

    mw_timer #(.SEC_TENS_RELOAD(4'd5)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .clearn(clearn),
        .load(load), .digit(digit), .mag_on(mag_on),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;      // time as a 4-digit decimal number MMSS
        bit done;
        bit pulse;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_id = 0;

    // Reference model: time as plain decimal MMSS, spec-level states.
    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2;
    localparam int RELOAD = 5;
    int m_v  = 0;
    int m_st = M_IDLE;

    task automatic step(input bit r, input bit c_n, input bit ld, input logic [3:0] d,
                        input bit m, input bit t);
        exp_t e;
        @(negedge clk);
        rst = r; clearn = c_n; load = ld; digit = d; mag_on = m; tick_1hz = t;
        e.pulse = 1'b0;
        if (r || !c_n) begin
            m_v  = 0;
            m_st = M_IDLE;
        end else if (ld && !m && d <= 4'd9) begin
            m_v  = (m_v * 10 + int'(d)) % 10000;
            m_st = (m_v != 0) ? M_SET : M_IDLE;
        end else if (m_st == M_SET) begin
            if (m) m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (!m) begin
                m_st = M_SET;
            end else if (t) begin
                if (m_v % 100 > 0) m_v = m_v - 1;
                else               m_v = m_v - 100 + RELOAD * 10 + 9;
                if (m_v == 0) begin
                    e.pulse = 1'b1;
                    m_st    = M_IDLE;
                end
            end
        end
        e.v    = m_v;
        e.done = (m_v == 0);
        e.id   = cyc_id;
        cyc_id++;
        exp_q.push_back(e);
    endtask

    task automatic key(input logic [3:0] d, input bit m);
        step(1'b0, 1'b1, 1'b1, d, m, 1'b0);
    endtask

    task automatic idle(input bit m);
        step(1'b0, 1'b1, 1'b0, 4'd0, m, 1'b0);
    endtask

    task automatic ticks(input int n, input bit m);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'd0, m, 1'b1);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents its registered outputs.
    initial begin
        exp_t       e;
        logic [15:0] act, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                want = {4'(e.v / 1000), 4'((e.v / 100) % 10), 4'((e.v / 10) % 10), 4'(e.v % 10)};
                act  = {min_tens, min_ones, sec_tens, sec_ones};
                checks++;
                if (act !== want || timer_done !== e.done || done_pulse !== e.pulse) begin
                    errors++;
                    $display("FAIL scoreboard step %0d: got time=%h done=%b pulse=%b, want time=%h done=%b pulse=%b",
                             e.id, act, timer_done, done_pulse, want, e.done, e.pulse);
                end
            end
        end
    end

    initial begin
        bit       m_rand;
        bit       r, c_n, ld, t;
        logic [3:0] d;
        int       drain;

        // Reset, then ticks with mag_on while idle
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        ticks(3, 1'b1);
        idle(1'b0);

        // Entry: 12:34, 23:49, invalid key, key while magnetron on
        key(4'd1, 1'b0); key(4'd2, 1'b0); key(4'd3, 1'b0); key(4'd4, 1'b0);
        key(4'd9, 1'b0);
        key(4'd12, 1'b0);
        key(4'd5, 1'b1);
        idle(1'b0);

        // Borrow across the minute, then full countdown
        do_clear();
        key(4'd1, 1'b0); key(4'd0, 1'b0); key(4'd0, 1'b0);
        idle(1'b1);
        ticks(1, 1'b1);
        ticks(59, 1'b1);
        idle(1'b1); idle(1'b0);

        // Pause and resume
        do_clear();
        key(4'd5, 1'b0);
        idle(1'b1);
        ticks(2, 1'b1);
        ticks(3, 1'b0);
        idle(1'b1);
        ticks(3, 1'b1);
        idle(1'b0);

        // Clear beats tick, clear beats load
        do_clear();
        key(4'd2, 1'b0);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        idle(1'b0);

        // 00:99 counts 99 seconds
        key(4'd9, 1'b0); key(4'd9, 1'b0);
        idle(1'b1);
        ticks(99, 1'b1);
        idle(1'b0);

        // Reset mid-run at 05:00
        key(4'd5, 1'b0); key(4'd0, 1'b0); key(4'd0, 1'b0);
        idle(1'b1);
        ticks(3, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Zero key on 00:00 stays idle; 1000 then 0 returns to zero
        key(4'd0, 1'b0);
        key(4'd1, 1'b0); key(4'd0, 1'b0); key(4'd0, 1'b0); key(4'd0, 1'b0);
        key(4'd0, 1'b0);
        ticks(2, 1'b1);

        // Randomized traffic
        m_rand = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 399) == 0);
            c_n = !($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            d   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) m_rand = ~m_rand;
            t   = ($urandom_range(0, 1) == 0);
            step(r, c_n, ld, d, m_rand, t);
        end
        idle(1'b0);

        // Drain the scoreboard with a bounded wait
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
